// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file with retire counter; optional WB_BYPASS_EN adds write-to-read bypass
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 6
`endif
`ifndef RNONE
`define RNONE 6'h3F
`endif

module wb_regfile #(
    parameter int NREG = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    W_stall_i,
    input  logic [6:0]              W_opcode_i,
    input  logic [`CPU_WIDTH-1:0]   W_valE_i,
    input  logic [`CPU_WIDTH-1:0]   W_valM_i,
    input  logic                    W_cnd_i,
    input  logic [`REG_WIDTH-1:0]   W_dstE_i,
    input  logic [`REG_WIDTH-1:0]   W_dstM_i,
    input  logic [`REG_WIDTH-1:0]   d_srcA_i,
    input  logic [`REG_WIDTH-1:0]   d_srcB_i,
    output logic [`CPU_WIDTH-1:0]   d_rvalA_o,
    output logic [`CPU_WIDTH-1:0]   d_rvalB_o,
    output logic                    retire_o,
    output logic                    retire_cnd_o,
    output logic [63:0]             instret_o
);

    localparam int          IDXW   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [31:0] NREG_U = NREG;

    logic [`CPU_WIDTH-1:0] r_regs [NREG];
    logic                  r_retire;
    logic                  r_retire_cnd;
    logic [63:0]           r_instret;

    logic            w_live;
    logic            w_weE;
    logic            w_weM;
    logic            w_okA;
    logic            w_okB;
    logic [IDXW-1:0] w_idxE;
    logic [IDXW-1:0] w_idxM;
    logic [IDXW-1:0] w_idxA;
    logic [IDXW-1:0] w_idxB;
    logic [`CPU_WIDTH-1:0] w_rvalA;
    logic [`CPU_WIDTH-1:0] w_rvalB;

    // A live instruction is a non-bubble that is not being held this cycle.
    assign w_live = (W_opcode_i != 7'h0) && !W_stall_i;

    assign w_weE = w_live && (W_dstE_i != `RNONE) && (W_dstE_i != '0)
                   && (32'(W_dstE_i) < NREG_U);
    assign w_weM = w_live && (W_dstM_i != `RNONE) && (W_dstM_i != '0)
                   && (32'(W_dstM_i) < NREG_U);

    assign w_okA = (d_srcA_i != `RNONE) && (d_srcA_i != '0) && (32'(d_srcA_i) < NREG_U);
    assign w_okB = (d_srcB_i != `RNONE) && (d_srcB_i != '0) && (32'(d_srcB_i) < NREG_U);

    assign w_idxE = W_dstE_i[IDXW-1:0];
    assign w_idxM = W_dstM_i[IDXW-1:0];
    assign w_idxA = d_srcA_i[IDXW-1:0];
    assign w_idxB = d_srcB_i[IDXW-1:0];

    // The M write comes last so it wins when both ports target one register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_weE) begin
                r_regs[w_idxE] <= W_valE_i;
            end
            if (w_weM) begin
                r_regs[w_idxM] <= W_valM_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_retire     <= 1'b0;
            r_retire_cnd <= 1'b0;
            r_instret    <= 64'd0;
        end else begin
            r_retire <= w_live;
            if (w_live) begin
                r_retire_cnd <= W_cnd_i;
                r_instret    <= r_instret + 64'd1;
            end
        end
    end

    always_comb begin
        w_rvalA = '0;
        if (w_okA) begin
`ifdef WB_BYPASS_EN
            if (w_weM && (d_srcA_i == W_dstM_i)) begin
                w_rvalA = W_valM_i;
            end else if (w_weE && (d_srcA_i == W_dstE_i)) begin
                w_rvalA = W_valE_i;
            end else begin
                w_rvalA = r_regs[w_idxA];
            end
`else
            w_rvalA = r_regs[w_idxA];
`endif
        end
    end

    always_comb begin
        w_rvalB = '0;
        if (w_okB) begin
`ifdef WB_BYPASS_EN
            if (w_weM && (d_srcB_i == W_dstM_i)) begin
                w_rvalB = W_valM_i;
            end else if (w_weE && (d_srcB_i == W_dstE_i)) begin
                w_rvalB = W_valE_i;
            end else begin
                w_rvalB = r_regs[w_idxB];
            end
`else
            w_rvalB = r_regs[w_idxB];
`endif
        end
    end

    assign d_rvalA_o    = w_rvalA;
    assign d_rvalB_o    = w_rvalB;
    assign retire_o     = r_retire;
    assign retire_cnd_o = r_retire_cnd;
    assign instret_o    = r_instret;

endmodule
